// File: rtl/ccff_loader_pkg.sv
// Shared types and helpers for the configuration-chain bitstream loader.
//   state_e   : loader FSM state encoding (3 bits)
//   RST_*     : reset values of the externally visible outputs
//   min_bits  : number of bits to take from the next word given bits left in the chain
package ccff_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam state_e RST_STATE  = ST_IDLE;
  localparam logic   RST_HEAD   = 1'b0;
  localparam logic   RST_CLK_EN = 1'b0;
  localparam logic   RST_ISOL_N = 1'b0;
  localparam logic   RST_DONE   = 1'b0;
  localparam logic   RST_ERROR  = 1'b0;
  localparam logic   RST_TAIL   = 1'b0;

  function automatic int unsigned min_bits(input int unsigned word_w,
                                           input int unsigned remaining);
    return (remaining < word_w) ? remaining : word_w;
  endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Word serializer for the configuration chain.
// Holds one bitstream word and presents it MSB first on a registered
// ccff_head, with ccff_clk_en high for exactly the cycles carrying a valid bit.
//   prog_clk, prog_reset_n : clock / async active-low reset
//   load, load_data, load_bits : capture a word and the number of its top bits to emit
//   shift      : advance to the next bit (parent is in its shift state)
//   clear      : drop the word immediately (abort)
//   word_last  : the bit on ccff_head this cycle is the last one of the word
//   ccff_head, ccff_clk_en : serial data and its per-bit enable
module ccff_word_serializer
  import ccff_loader_pkg::*;
#(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned WB_W   = $clog2(WORD_W + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              load,
  input  logic              shift,
  input  logic              clear,
  input  logic [WORD_W-1:0] load_data,
  input  logic [WB_W-1:0]   load_bits,
  output logic              word_last,
  output logic              ccff_head,
  output logic              ccff_clk_en
);

  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic [WB_W-1:0]   wbits_q, wbits_d;
  logic              head_q, head_d;
  logic              en_q, en_d;

  // The MSB is moved straight into head_q on load so the first bit is on the
  // chain the cycle after the handshake; sreg then holds the bits still to come.
  always_comb begin
    sreg_d  = sreg_q;
    wbits_d = wbits_q;
    head_d  = head_q;
    en_d    = en_q;
    if (clear) begin
      sreg_d  = '0;
      wbits_d = '0;
      head_d  = RST_HEAD;
      en_d    = RST_CLK_EN;
    end else if (load) begin
      head_d  = load_data[WORD_W-1];
      en_d    = 1'b1;
      sreg_d  = load_data << 1;
      wbits_d = load_bits;
    end else if (shift) begin
      if (wbits_q > WB_W'(1)) begin
        head_d  = sreg_q[WORD_W-1];
        en_d    = 1'b1;
        sreg_d  = sreg_q << 1;
        wbits_d = wbits_q - WB_W'(1);
      end else begin
        // Last bit of the word is going out now; unused low bits are discarded.
        head_d  = 1'b0;
        en_d    = 1'b0;
        sreg_d  = '0;
        wbits_d = '0;
      end
    end
  end

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      sreg_q  <= '0;
      wbits_q <= '0;
      head_q  <= RST_HEAD;
      en_q    <= RST_CLK_EN;
    end else begin
      sreg_q  <= sreg_d;
      wbits_q <= wbits_d;
      head_q  <= head_d;
      en_q    <= en_d;
    end
  end

  assign word_last   = (wbits_q == WB_W'(1));
  assign ccff_head   = head_q;
  assign ccff_clk_en = en_q;

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Configuration-chain driver feeding the tile ccff_head input.
// Accepts bitstream words on a valid/ready stream, shifts exactly CHAIN_LEN
// bits MSB first into the chain, and keeps the fabric IO isolated until a
// fixed hold after the final bit.
//   prog_clk, prog_reset_n : clock / async active-low reset
//   start, abort           : single-cycle control pulses
//   s_valid, s_data, s_ready : bitstream word stream
//   ccff_head, ccff_clk_en : serial chain data and per-bit shift enable
//   ccff_tail              : chain output, captured for debug only
//   IO_ISOL_N              : fabric IO isolation (0 = isolated)
//   busy, done, error      : status
module ccff_bitstream_loader
  import ccff_loader_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 4096,
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned ISOL_HOLD = 4,
  parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic              s_valid,
  input  logic [WORD_W-1:0] s_data,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              ccff_clk_en,
  input  logic              ccff_tail,
  output logic              IO_ISOL_N,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int unsigned WB_W   = $clog2(WORD_W + 1);
  localparam int unsigned HOLD_W = (ISOL_HOLD > 0) ? $clog2(ISOL_HOLD + 1) : 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic               io_isol_n_q, io_isol_n_d;
  logic               tail_q;

  logic               ser_load, ser_shift, ser_clear, word_last;
  logic [WB_W-1:0]    load_bits;

  assign load_bits = WB_W'(min_bits(WORD_W, 32'(remaining_q)));

  // State register
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state_q     <= RST_STATE;
      remaining_q <= '0;
      hold_q      <= '0;
      done_q      <= RST_DONE;
      error_q     <= RST_ERROR;
      io_isol_n_q <= RST_ISOL_N;
      tail_q      <= RST_TAIL;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      hold_q      <= hold_d;
      done_q      <= done_d;
      error_q     <= error_d;
      io_isol_n_q <= io_isol_n_d;
      tail_q      <= ccff_tail;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    hold_d      = hold_q;
    error_d     = error_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_FETCH;
          remaining_d = CNT_W'(CHAIN_LEN);
          error_d     = 1'b0;
        end
      end
      ST_FETCH: begin
        if (abort) begin
          state_d = ST_IDLE;
          error_d = 1'b1;
        end else if (s_valid) begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          state_d = ST_IDLE;
          error_d = 1'b1;
        end else begin
          remaining_d = remaining_q - CNT_W'(1);
          // min_bits keeps the word boundary aligned with the chain end, so
          // remaining reaching zero always coincides with the word emptying.
          if (remaining_q == CNT_W'(1)) begin
            if (ISOL_HOLD == 0) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_HOLD;
              hold_d  = HOLD_W'(ISOL_HOLD);
            end
          end else if (word_last) begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_HOLD: begin
        if (abort) begin
          state_d = ST_IDLE;
          error_d = 1'b1;
        end else if (hold_q <= HOLD_W'(1)) begin
          state_d = ST_DONE;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Both flags follow the DONE state: set on entry, cleared by start, untouched by abort.
    done_d      = (state_d == ST_DONE);
    io_isol_n_d = (state_d == ST_DONE);
  end

  // Output logic
  always_comb begin
    s_ready   = 1'b0;
    busy      = 1'b0;
    ser_load  = 1'b0;
    ser_shift = 1'b0;
    ser_clear = 1'b0;
    case (state_q)
      ST_FETCH: begin
        s_ready   = 1'b1;
        busy      = 1'b1;
        ser_load  = s_valid && !abort;
        ser_clear = abort;
      end
      ST_SHIFT: begin
        busy      = 1'b1;
        ser_shift = !abort;
        ser_clear = abort;
      end
      ST_HOLD: begin
        busy      = 1'b1;
        ser_clear = abort;
      end
      default: ;
    endcase
  end

  ccff_word_serializer #(
    .WORD_W (WORD_W)
  ) u_ser (
    .prog_clk     (prog_clk),
    .prog_reset_n (prog_reset_n),
    .load         (ser_load),
    .shift        (ser_shift),
    .clear        (ser_clear),
    .load_data    (s_data),
    .load_bits    (load_bits),
    .word_last    (word_last),
    .ccff_head    (ccff_head),
    .ccff_clk_en  (ccff_clk_en)
  );

  assign IO_ISOL_N = io_isol_n_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: doc/ccff_bitstream_loader.md
Name: ccff_bitstream_loader

Overview:
- Configuration-chain driver that sits directly upstream of the tile ccff_head inputs.
- Accepts bitstream words over a valid/ready stream and serializes them, MSB first, into the fabric configuration chain.
- Emits a per-bit shift enable, which the integration level uses to gate prog_clk through an ICG.
- Drives the fabric IO_ISOL_N: low for the whole programming sequence, released after a fixed hold once the last bit is shifted.

Parameters:
- CHAIN_LEN, 4096: total configuration bits in the chain; must be ≥1.
- WORD_W, 32: input word width; must be ≥2.
- ISOL_HOLD, 4: prog_clk cycles between the last shift and IO_ISOL_N release; 0 is legal.
- CNT_W, $clog2(CHAIN_LEN+1): remaining-bit counter width; derived, not overridden.

Ports:
- prog_clk  input  1  programming clock; all state on its rising edge.
- prog_reset_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; begins a load sequence from IDLE or DONE.
- abort  input  1  single-cycle pulse; terminates a sequence in progress.
- s_valid  input  1  bitstream word valid.
- s_data  input  WORD_W  bitstream word; bit WORD_W-1 is shifted first.
- s_ready  output  1  loader can accept a word this cycle.
- ccff_head  output  1  serial configuration data to the first tile.
- ccff_clk_en  output  1  high for exactly the cycles in which ccff_head carries a valid bit.
- ccff_tail  input  1  chain output; registered into tail_q for debug only, no control use.
- IO_ISOL_N  output  1  fabric IO isolation; 0 = isolated.
- busy  output  1  high in FETCH, SHIFT and HOLD.
- done  output  1  sequence completed; cleared by the next start.
- error  output  1  sequence aborted; cleared by the next start.

Behaviour:
- Clock and reset: one clock, prog_clk; prog_reset_n is asynchronous assert, synchronous deassert at integration level.
- Reset values:
  - ccff_head=0, ccff_clk_en=0, s_ready=0
  - IO_ISOL_N=0 (fabric stays isolated until a completed load)
  - busy=0, done=0, error=0, tail_q=0, state=IDLE
- States: IDLE, FETCH, SHIFT, HOLD, DONE.
- IDLE/DONE:
  - s_ready=0.
  - start → FETCH; remaining=CHAIN_LEN; done=0, error=0; IO_ISOL_N=0 next cycle.
- FETCH:
  - s_ready=1 (combinational from state).
  - On s_valid&&s_ready: sreg←s_data; wbits←min(WORD_W, remaining); go to SHIFT.
  - No s_valid: hold; ccff_clk_en=0.
- SHIFT, every cycle:
  - ccff_head←sreg[WORD_W-1] (registered); ccff_clk_en←1.
  - sreg←sreg<<1; wbits--; remaining--.
  - If remaining becomes 0 → HOLD, hold counter=ISOL_HOLD.
  - Else if wbits becomes 0 → FETCH.
- Latency and throughput:
  - A word accepted in cycle N puts its first bit on ccff_head/ccff_clk_en in cycle N+1.
  - One word costs wbits+1 cycles; no back-to-back prefetch.
- Final partial word: when CHAIN_LEN mod WORD_W ≠ 0, only the top (CHAIN_LEN mod WORD_W) bits of the last word are shifted. The low bits are discarded, no extra word is requested, and s_ready never rises after the final word.
- HOLD:
  - ccff_clk_en=0, ccff_head=0.
  - Count down ISOL_HOLD cycles, then DONE: done=1, IO_ISOL_N=1, busy=0.
  - ISOL_HOLD=0 enters DONE the cycle after the last shift.
- Abort:
  - When busy: next cycle state=IDLE, error=1, ccff_clk_en=0, IO_ISOL_N stays 0, remaining words are not consumed.
  - Ignored in IDLE/DONE.
- start while busy is ignored.
- start and abort in the same cycle while busy: abort wins.
- start and abort in the same cycle in IDLE/DONE: start wins.
- Reset mid-operation returns every output to its reset value immediately. No partial-chain recovery: the host must rerun the full sequence.
- Counter widths: remaining is CNT_W bits and wbits is $clog2(WORD_W+1) bits; neither counter wraps, because of the state guards.

Decomposition:
- ccff_loader_pkg:
  - state enum (3-bit encoding)
  - function min_bits(word_w, remaining)
  - localparams for reset values
- One sub-module, ccff_word_serializer, owning:
  - sreg, wbits and the registered ccff_head/ccff_clk_en
  - load/shift/empty handshake to the parent FSM
- The parent owns the FSM, remaining, the hold counter, IO_ISOL_N and the status flags.

Test Plan:
- Partial final word: CHAIN_LEN=10, WORD_W=4, ISOL_HOLD=2; start, words 0xA, 0x5, 0xC, s_valid always high → ccff_head on the 10 en-cycles = 1,0,1,0,0,1,0,1,1,1; 3 words accepted; IO_ISOL_N=1 and done=1 exactly 3 cycles after the last en-cycle.
- Stall: same config; s_valid low for 5 cycles between words 1 and 2 → ccff_clk_en low for exactly those cycles; bit sequence unchanged; total en-cycles = 10.
- Exact multiple: CHAIN_LEN=8, WORD_W=4, words 0xF, 0x0 → head = 1111 0000; s_ready never asserted after the second handshake.
- Abort and restart: abort after the 5th en-cycle → next cycle error=1, busy=0, IO_ISOL_N=0, ccff_clk_en=0. A following start clears error and reloads all 10 bits.
- Reset mid-SHIFT: drop prog_reset_n asynchronously mid-cycle → all outputs at reset values before the next edge; a start after release performs a full load.
- Collisions: start pulsed during SHIFT → ignored, bit count still 10. Start and abort together in DONE → new sequence begins, done=0, error=0.
